// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and the single-step normalizer used by fp_pack.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int SIG_W    = 28;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 10;
  localparam int EXP_IW   = 11;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG = 32'h7F80_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_NORM  = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic                     need;
    logic                     flush;
    logic [SIG_W-1:0]         sig;
    logic signed [EXP_IW-1:0] expo;
  } norm_step_t;

  // One normalization step; need=0 means the value is ready for rounding.
  function automatic norm_step_t norm_step(input logic [SIG_W-1:0] sig,
                                           input logic signed [EXP_IW-1:0] expo,
                                           input logic subn_en);
    norm_step_t r;
    r.need  = 1'b0;
    r.flush = 1'b0;
    r.sig   = sig;
    r.expo  = expo;
    if (sig[27]) begin
      r.need = 1'b1;
      r.sig  = {1'b0, sig[27:2], sig[1] | sig[0]};
      r.expo = expo + 11'sd1;
    end else if (!sig[26] && (expo > 11'sd1)) begin
      r.need = 1'b1;
      r.sig  = {sig[26:0], 1'b0};
      r.expo = expo - 11'sd1;
    end else if (expo < 11'sd1) begin
      if (subn_en) begin
        r.need = 1'b1;
        r.sig  = {1'b0, sig[27:2], sig[1] | sig[0]};
        r.expo = expo + 11'sd1;
      end else begin
        r.flush = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even on a normalized significand, with carry renormalization.
module fp_round
  import fp_pkg::*;
(
  input  logic [26:0]        sig_i,
  input  logic signed [10:0] exp_i,
  output logic [23:0]        man_o,
  output logic signed [10:0] exp_o,
  output logic               inexact_o
);

  logic        round_up;
  logic [24:0] sum;

  always_comb begin
    inexact_o = |sig_i[2:0];
    // Ties go up only when the kept LSB is odd.
    round_up  = sig_i[2] & (sig_i[1] | sig_i[0] | sig_i[3]);
    sum       = {1'b0, sig_i[26:3]} + {24'd0, round_up};
    if (sum[24]) begin
      man_o = sum[24:1];
      exp_o = exp_i + 11'sd1;
    end else begin
      man_o = sum[23:0];
      exp_o = exp_i;
    end
  end

endmodule

// File: rtl/fp_pack.sv
// Normalize, round and pack an unpacked single-precision result into IEEE 754 format.
// Define FP_PACK_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to zero.
module fp_pack
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [27:0] sig_in,
  input  logic        zero_in,
  input  logic        inf_in,
  input  logic        nan_in,
  output logic [31:0] flp_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic [1:0]  dbg_state
);

`ifdef FP_PACK_SUBNORMAL_EN
  localparam logic SUBNORMAL_EN = 1'b1;
`else
  localparam logic SUBNORMAL_EN = 1'b0;
`endif

  localparam int KW = $clog2(MAX_SHIFT + 2);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [10:0] exp_q, exp_d;
  logic [27:0]        sig_q, sig_d;
  logic [KW-1:0]      k_q, k_d;
  logic               flush_q, flush_d;
  logic [31:0]        flp_q, flp_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inx_q, inx_d;

  logic [27:0]        cur_sig;
  logic signed [10:0] cur_exp;
  logic [KW-1:0]      cur_k;
  logic               norm_active;
  norm_step_t         ns;

  logic [23:0]        rnd_man;
  logic signed [10:0] rnd_exp;
  logic               rnd_inexact;

  fp_round u_round (
    .sig_i     (sig_q[26:0]),
    .exp_i     (exp_q),
    .man_o     (rnd_man),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    k_d         = k_q;
    flush_d     = flush_q;
    flp_d       = flp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    norm_active = 1'b0;

    // The first step is evaluated on the incoming operand so an already
    // normalized value skips NORM entirely.
    cur_sig = (state_q == ST_IDLE) ? sig_in : sig_q;
    cur_exp = (state_q == ST_IDLE) ? {exp_in[9], exp_in} : exp_q;
    cur_k   = (state_q == ST_IDLE) ? '0 : k_q;
    ns      = norm_step(cur_sig, cur_exp, SUBNORMAL_EN);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          flush_d = 1'b0;
          if (nan_in) begin
            flp_d   = QNAN;
            state_d = ST_DONE;
          end else if (inf_in) begin
            flp_d   = {sign_in, INF_MAG[30:0]};
            state_d = ST_DONE;
          end else if (zero_in || (sig_in == 28'd0)) begin
            flp_d   = {sign_in, 31'd0};
            state_d = ST_DONE;
          end else begin
            norm_active = 1'b1;
          end
        end
      end
      ST_NORM: norm_active = 1'b1;
      ST_ROUND: begin
        state_d = ST_DONE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        inx_d   = rnd_inexact;
        if (flush_q) begin
          flp_d = {sign_q, 31'd0};
          unf_d = 1'b1;
          inx_d = 1'b1;
        end else if (rnd_exp >= $signed(11'(EXP_MAX))) begin
          flp_d = {sign_q, INF_MAG[30:0]};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (!rnd_man[23]) begin
          if (SUBNORMAL_EN) begin
            flp_d = {sign_q, 8'd0, rnd_man[22:0]};
            unf_d = rnd_inexact;
          end else begin
            flp_d = {sign_q, 31'd0};
            unf_d = 1'b1;
            inx_d = 1'b1;
          end
        end else begin
          flp_d = {sign_q, rnd_exp[7:0], rnd_man[22:0]};
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (norm_active) begin
      if (ns.need) begin
        if (cur_k == KW'(MAX_SHIFT)) begin
          flp_d   = {sign_d, 31'd0};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          inx_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          sig_d   = ns.sig;
          exp_d   = ns.expo;
          k_d     = cur_k + KW'(1);
          state_d = ST_NORM;
        end
      end else begin
        sig_d   = cur_sig;
        exp_d   = cur_exp;
        k_d     = cur_k;
        flush_d = ns.flush;
        state_d = ST_ROUND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      k_q     <= '0;
      flush_q <= 1'b0;
      flp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      k_q     <= k_d;
      flush_q <= flush_d;
      flp_q   <= flp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign flp_out   = flp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_pack.sv
// Directed-vector bench for fp_pack: values, status flags, latency, hold and reset behaviour.
module tb_fp_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [27:0] sig_in;
  logic        zero_in, inf_in, nan_in;
  logic [31:0] flp_out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow, underflow, inexact;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .sig_in    (sig_in),
    .zero_in   (zero_in),
    .inf_in    (inf_in),
    .nan_in    (nan_in),
    .flp_out   (flp_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic drive_in(input logic s, input logic [9:0] e, input logic [27:0] m,
                          input logic z, input logic i, input logic n);
    sign_in  = s;
    exp_in   = e;
    sig_in   = m;
    zero_in  = z;
    inf_in   = i;
    nan_in   = n;
    in_valid = 1'b1;
  endtask

  // flags = {overflow, underflow, inexact}; latency counted in cycles after the accept cycle.
  task automatic run_op(input string tag, input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic z, input logic i, input logic n,
                        input logic [31:0] want_flp, input logic [2:0] want_flags, input int want_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    drive_in(s, e, m, z, i, n);
    exp_q.push_back(want_flp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, want_lat);
    check({tag, "_flp"}, flp_out, exp_q.pop_front());
    check({tag, "_flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, want_flags});
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 10'd0, 28'd0, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_flp", flp_out, 32'd0);
    check("rst_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("norm_1p5",  1'b0, 10'd127, 28'h6000000, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 3'b000, 2);
    release_out("norm_1p5");
    run_op("ovf_shift", 1'b0, 10'd127, 28'h8000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000, 3);
    release_out("ovf_shift");
    run_op("rnd_carry", 1'b0, 10'd127, 28'h7FFFFFC, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001, 2);
    release_out("rnd_carry");
    run_op("tie_even",  1'b0, 10'd127, 28'h4000004, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001, 2);
    release_out("tie_even");
    run_op("tie_odd",   1'b0, 10'd127, 28'h400000C, 1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b001, 2);
    release_out("tie_odd");
    run_op("exp_ovf",   1'b0, 10'd255, 28'h4000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101, 2);
    release_out("exp_ovf");
    run_op("carry_ovf", 1'b1, 10'd254, 28'h7FFFFFC, 1'b0, 1'b0, 1'b0, 32'hFF800000, 3'b101, 2);
    release_out("carry_ovf");
    run_op("lshift23",  1'b0, 10'd127, 28'h0000008, 1'b0, 1'b0, 1'b0, 32'h34000000, 3'b000, 25);
    release_out("lshift23");
    run_op("neg_3",     1'b1, 10'd128, 28'h6000000, 1'b0, 1'b0, 1'b0, 32'hC0400000, 3'b000, 2);
    release_out("neg_3");
    run_op("nan_prio",  1'b1, 10'd127, 28'h6000000, 1'b1, 1'b1, 1'b1, 32'h7FC00000, 3'b000, 1);
    release_out("nan_prio");
    run_op("inf_neg",   1'b1, 10'd127, 28'h6000000, 1'b1, 1'b1, 1'b0, 32'hFF800000, 3'b000, 1);
    release_out("inf_neg");
    run_op("zero_neg",  1'b1, 10'd127, 28'h6000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 3'b000, 1);
    release_out("zero_neg");
    run_op("sig_zero",  1'b1, 10'd127, 28'h0000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b000, 1);
    release_out("sig_zero");
`ifdef FP_PACK_SUBNORMAL_EN
    run_op("tiny",      1'b0, 10'd0,   28'h4000000, 1'b0, 1'b0, 1'b0, 32'h00400000, 3'b000, 3);
    release_out("tiny");
    run_op("deep_tiny", 1'b1, 10'h39C, 28'h4000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011, 27);
    release_out("deep_tiny");
`else
    run_op("tiny",      1'b0, 10'd0,   28'h4000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011, 2);
    release_out("tiny");
    run_op("deep_tiny", 1'b1, 10'h39C, 28'h4000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011, 2);
    release_out("deep_tiny");
`endif

    // Result must hold while the consumer stalls.
    run_op("hold", 1'b0, 10'd127, 28'h6000000, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 3'b000, 2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_flp", flp_out, 32'h3FC00000);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    release_out("hold");

    // Reset while normalizing discards the operation.
    @(negedge clk);
    drive_in(1'b0, 10'd127, 28'h0000008, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_norm", {30'd0, dbg_state}, 32'd1);
    check("mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_flp", flp_out, 32'd0);
    check("mid_rst_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("after_rst", 1'b0, 10'd127, 28'h6000000, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 3'b000, 2);
    release_out("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
